nibble_parity_rx: RTL
=====================

# nibble_parity_rx

Serial front-end stage that deframes a one-bit line into 4-bit nibbles `{a,b,c,d}` and presents them to the downstream 4-input parity stage. It also checks each nibble against a transmitted parity bit, where parity is the XOR of the four data bits. Each received frame is start(0), four data bits (a first), parity, stop(1). The block reports frame completion, parity mismatches, framing errors and a saturating error count.

## Interface
- `ERR_W`, 8, width of the error counter.

- `clk`  in  1  rising-edge clock; the line is sampled once per cycle.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  1  serial line; idles high.
- `nibble`  out  4  last well-framed data, `{a,b,c,d}`; `a` (first data bit) is `nibble[3]`.
- `par`  out  1  `^nibble`, the expected parity of the held nibble.
- `done`  out  1  one-cycle pulse when a well-framed frame completes.
- `par_err`  out  1  valid with `done`; high when the received parity bit ≠ `^nibble`.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `err_count`  out  ERR_W  count of `par_err` and `frame_err` events; saturates.

## Operation
- States and transitions:
  - IDLE: `in`=0 → D0; otherwise stay.
  - D0..D3: shift `in` into the data shift register (D0→`a` … D3→`d`), then advance.
  - PAR: capture `in` as `rx_par`; go to STOP.
  - STOP: `in`=1 → DONE; `in`=0 → WAIT.
  - DONE (lasts one cycle, `done`=1): `in`=0 → D0 (back-to-back start bit); otherwise IDLE.
  - WAIT: stay until `in`=1, then IDLE. A 0 seen in WAIT is never treated as a start bit.
- On the STOP→DONE transition, load `nibble` from the shift register and `par_err` ← `rx_par ^ (^shift)`.
- `nibble`, `par` and `par_err` hold until the next load. `par` is combinational XOR of `nibble`.
- `frame_err` is asserted on the cycle after STOP samples 0, which is the first cycle in WAIT.
- Frames that end in `frame_err` never update `nibble` or `par_err` and never assert `done`.
- `err_count` increments by 1 in the cycle `done && par_err` or `frame_err` is high.
  - At most one event can occur per cycle.
  - It holds at `2^ERR_W-1`; no wrap.
- `err_count` is cleared only by reset.

## Timing
- Reset values: state IDLE; `nibble`=0, `par`=0, `done`=0, `par_err`=0, `frame_err`=0, `err_count`=0; shift register 0.
- Reset mid-frame aborts the frame. Partial data is discarded. `in` is ignored in the reset cycle; the cycle after reset deasserts is evaluated in IDLE.
- Frame latency: if the start bit is sampled at edge N, data is sampled at N+1..N+4, parity at N+5 and stop at N+6.
  - On a good stop bit, `done`, `nibble` and `par_err` are visible after edge N+6 (during cycle N+7).
  - On a low stop bit, `frame_err` is visible during cycle N+7.
- Sustained throughput: one frame per 7 cycles when the next start bit is sampled in the DONE cycle.
- All outputs are registered except `par`.

## Test plan
- **Good frame.** Idle high, then 0, 1,0,1,1, p=1, 1 → `done`=1 for exactly one cycle at N+7, `nibble`=4'hB, `par`=1, `par_err`=0, `err_count`=0.
- **Parity mismatch.** Same frame with p=0 → `done`=1, `nibble`=4'hB, `par_err`=1, `err_count`=1.
- **Framing error.** 0, 0,1,1,0, p=0, stop=0, then line held 0 for 5 cycles, then 1 → `frame_err` pulses once, no `done`, `nibble` unchanged, `err_count`+1. A following good frame for 4'h6 (p=0) completes normally.
- **Back-to-back.** Frames 4'hF (p=0) and 4'h1 (p=1), with the second start bit in the DONE cycle → two `done` pulses 7 cycles apart, `nibble` 4'hF then 4'h1, `par` 0 then 1.
- **Reset mid-frame.** Assert `reset` after 2 data bits of a frame → all outputs 0. A complete frame for 4'h9 (p=0) started afterwards gives `done`, `nibble`=4'h9, `par_err`=0.
- **Saturation.** With `ERR_W`=2, send 5 parity-error frames → `err_count` reads 1,2,3,3,3.

Source files
------------

// File: rtl/nibble_parity_rx_if.sv
// nibble_parity_rx_if
//   Bundles the serial line and the deframed nibble outputs of nibble_parity_rx.
//   slave  : the receiver (samples in, drives the result signals)
//   master : the line driver / downstream consumer
// Signals:
//   in         serial line, idles high
//   nibble     last well-framed data {a,b,c,d}
//   par        ^nibble
//   done       one-cycle pulse per well-framed frame
//   par_err    parity mismatch flag, valid with done, held until next load
//   frame_err  one-cycle pulse on a low stop bit
//   err_count  saturating count of parity and framing errors
interface nibble_parity_rx_if #(
    parameter int ERR_W = 8
);
    logic             in;
    logic [3:0]       nibble;
    logic             par;
    logic             done;
    logic             par_err;
    logic             frame_err;
    logic [ERR_W-1:0] err_count;

    modport slave (
        input  in,
        output nibble, par, done, par_err, frame_err, err_count
    );

    modport master (
        output in,
        input  nibble, par, done, par_err, frame_err, err_count
    );
endinterface

// File: rtl/nibble_parity_rx.sv
// nibble_parity_rx
//   Deframes a one-bit line (start 0, a, b, c, d, parity, stop 1) into a
//   4-bit nibble and checks it against the transmitted even-XOR parity bit.
// Ports:
//   clk    rising-edge clock, line sampled once per cycle
//   reset  synchronous, active-high
//   bus    nibble_parity_rx_if.slave (in, nibble, par, done, par_err,
//          frame_err, err_count)
module nibble_parity_rx #(
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    nibble_parity_rx_if.slave   bus
);
    typedef enum logic [3:0] {
        IDLE, D0, D1, D2, D3, PAR, STOP, DONE, WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       shift_q;
    logic             rx_par_q;
    logic [3:0]       nib_q;
    logic             par_err_q;
    logic             done_q;
    logic             frame_err_q;
    logic [ERR_W-1:0] err_q;

    logic             shift_en;
    logic             load;
    logic             ferr_set;
    logic             new_par_err;

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        load     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: if (!bus.in) state_d = D0;
            D0:   begin shift_en = 1'b1; state_d = D1;  end
            D1:   begin shift_en = 1'b1; state_d = D2;  end
            D2:   begin shift_en = 1'b1; state_d = D3;  end
            D3:   begin shift_en = 1'b1; state_d = PAR; end
            PAR:  state_d = STOP;
            STOP: begin
                if (bus.in) begin
                    load    = 1'b1;
                    state_d = DONE;
                end else begin
                    ferr_set = 1'b1;
                    state_d  = WAIT;
                end
            end
            // A low line in DONE is the next frame's start bit.
            DONE: state_d = bus.in ? IDLE : D0;
            // Line stuck low after a bad stop bit is not a start bit.
            WAIT: if (bus.in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign new_par_err = rx_par_q ^ (^shift_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            rx_par_q    <= 1'b0;
            nib_q       <= '0;
            par_err_q   <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= load;
            frame_err_q <= ferr_set;
            // First data bit ends up in shift_q[3] after four shifts.
            if (shift_en)       shift_q  <= {shift_q[2:0], bus.in};
            if (state_q == PAR) rx_par_q <= bus.in;
            if (load) begin
                nib_q     <= shift_q;
                par_err_q <= new_par_err;
            end
            // Count updates on the same edge that raises done/frame_err.
            if (((load && new_par_err) || ferr_set) && (err_q != '1))
                err_q <= err_q + ERR_W'(1);
        end
    end

    assign bus.nibble    = nib_q;
    assign bus.par       = ^nib_q;
    assign bus.done      = done_q;
    assign bus.par_err   = par_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_q;
endmodule
